// File: rtl/seq_shift_add_multiplier.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH iterative shift-and-add multiplier.
// One partial product per cycle through a single adder; start/busy/done handshake.

module cla_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p;
  logic [7:0]  grp_g, grp_p;
  logic [8:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Two-level lookahead: 4-bit groups, group carries resolved serially below.
  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    logic [3:0] cb;

    assign grp_g[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign grp_p[k] = &p[B+3:B];

    assign cb[0] = gc[k];
    assign cb[1] = g[B] | (p[B] & gc[k]);
    assign cb[2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign cb[3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                 | (p[B+2] & p[B+1] & p[B] & gc[k]);
    assign sum[B+3:B] = p[B+3:B] ^ cb;
  end

  always_comb begin
    gc = '0;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = grp_g[k] | (grp_p[k] & gc[k]);
    end
  end

  assign cout = gc[8];
endmodule

// State table
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | one shift-and-add iteration per cycle, busy=1
//   DONE  | product valid and held, done=1; start restarts
module seq_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg, a_nxt;
  logic [2*WIDTH-1:0] p_reg, p_nxt;
  logic [CNT_W-1:0]   count, count_nxt;

  logic [WIDTH-1:0]   add_x, add_y, add_sum;
  logic               add_cout;

  assign add_x = p_reg[2*WIDTH-1:WIDTH];
  assign add_y = p_reg[0] ? a_reg : '0;

  if (WIDTH == 32) begin : g_cla
    cla_adder u_add (
      .a    (add_x),
      .b    (add_y),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
    );
  end else begin : g_beh
    assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      p_reg <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      a_reg <= a_nxt;
      p_reg <= p_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    p_nxt     = p_reg;
    count_nxt = count;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_nxt     = a;
          p_nxt     = {{WIDTH{1'b0}}, b};
          count_nxt = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Carry-out lands in the top bit so the partial sum is never truncated.
        p_nxt     = {add_cout, add_sum, p_reg[WIDTH-1:1]};
        count_nxt = count + 1'b1;
        if (count == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = p_reg;
endmodule
